// File: rtl/block_stream_gen_pkg.sv
// Shared types and constants for the keyword stream generator.
// BLOCK_STREAM_GEN_UPPER_EN selects uppercase keywords.
package block_stream_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WORD = 2'd1,
    SEP  = 2'd2
  } state_t;

  localparam logic CMD_BEGIN = 1'b0;
  localparam logic CMD_END   = 1'b1;

  localparam logic [7:0] CH_B     = 8'h62;
  localparam logic [7:0] CH_E     = 8'h65;
  localparam logic [7:0] CH_G     = 8'h67;
  localparam logic [7:0] CH_I     = 8'h69;
  localparam logic [7:0] CH_N     = 8'h6E;
  localparam logic [7:0] CH_D     = 8'h64;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_NUL   = 8'h00;

  localparam logic [2:0] LEN_BEGIN = 3'd5;
  localparam logic [2:0] LEN_END   = 3'd3;

  // Letters are stored lowercase; clearing bit 5 gives the uppercase form.
  function automatic logic [7:0] kw_case(input logic [7:0] c);
`ifdef BLOCK_STREAM_GEN_UPPER_EN
    return c & 8'hDF;
`else
    return c;
`endif
  endfunction

endpackage

// File: rtl/block_stream_gen_rom.sv
// Keyword character lookup: (cmd, index) -> ASCII byte, purely combinational.
// Case selection follows BLOCK_STREAM_GEN_UPPER_EN through the package helper.
module block_stream_gen_rom
  import block_stream_gen_pkg::*;
(
  input  logic       cmd,
  input  logic [2:0] idx,
  output logic [7:0] char_out
);

  always_comb begin
    char_out = CH_NUL;
    if (cmd == CMD_BEGIN) begin
      case (idx)
        3'd0:    char_out = kw_case(CH_B);
        3'd1:    char_out = kw_case(CH_E);
        3'd2:    char_out = kw_case(CH_G);
        3'd3:    char_out = kw_case(CH_I);
        3'd4:    char_out = kw_case(CH_N);
        default: char_out = CH_NUL;
      endcase
    end else begin
      case (idx)
        3'd0:    char_out = kw_case(CH_E);
        3'd1:    char_out = kw_case(CH_N);
        3'd2:    char_out = kw_case(CH_D);
        default: char_out = CH_NUL;
      endcase
    end
  end

endmodule

// File: rtl/block_stream_gen.sv
// Emits "begin " / "end " byte streams for nesting commands and tracks depth.
// Build with BLOCK_STREAM_GEN_UPPER_EN for uppercase keywords.
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high, out_valid low
// WORD  | presenting keyword character idx of cur_cmd
// SEP   | presenting the trailing space
module block_stream_gen
  import block_stream_gen_pkg::*;
#(
  parameter int MAX_DEPTH = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_char,
  output logic [7:0] depth,
  output logic       balanced,
  output logic       err
);

  localparam logic [7:0] MAX_D = 8'(MAX_DEPTH);

  state_t     state;
  logic [2:0] idx;
  logic       cur_cmd;
  logic       rom_cmd;
  logic [2:0] rom_idx;
  logic [7:0] rom_char;
  logic [2:0] last_idx;
  logic       accept;
  logic       out_hs;
  logic       legal;

  assign accept   = cmd_valid && cmd_ready;
  assign out_hs   = out_valid && out_ready;
  assign legal    = (cmd == CMD_END) ? (depth != 8'd0) : (depth != MAX_D);
  assign last_idx = (cur_cmd == CMD_END) ? (LEN_END - 3'd1) : (LEN_BEGIN - 3'd1);
  assign balanced = (depth == 8'd0);

  // One lookup serves both the first char on accept and the next char in WORD.
  assign rom_cmd = (state == IDLE) ? cmd : cur_cmd;
  assign rom_idx = (state == IDLE) ? 3'd0 : (idx + 3'd1);

  block_stream_gen_rom u_rom (
    .cmd      (rom_cmd),
    .idx      (rom_idx),
    .char_out (rom_char)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 3'd0;
      cur_cmd   <= CMD_BEGIN;
      depth     <= 8'd0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_char  <= CH_NUL;
      cmd_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            if (legal) begin
              state     <= WORD;
              idx       <= 3'd0;
              cur_cmd   <= cmd;
              out_valid <= 1'b1;
              out_char  <= rom_char;
              cmd_ready <= 1'b0;
              depth     <= (cmd == CMD_END) ? (depth - 8'd1) : (depth + 8'd1);
            end else begin
              err <= 1'b1;
            end
          end
        end
        WORD: begin
          if (out_hs) begin
            if (idx == last_idx) begin
              state    <= SEP;
              out_char <= CH_SPACE;
            end else begin
              idx      <= idx + 3'd1;
              out_char <= rom_char;
            end
          end
        end
        SEP: begin
          if (out_hs) begin
            state     <= IDLE;
            idx       <= 3'd0;
            out_valid <= 1'b0;
            out_char  <= CH_NUL;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_stream_gen.sv
// Scoreboard bench for block_stream_gen: directed scenarios plus random commands
// against a string-based keyword model with a small nesting limit.
module tb_block_stream_gen;

  localparam int MAXD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd = 1'b0;
  logic       cmd_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_char;
  logic [7:0] depth;
  logic       balanced;
  logic       err;

  logic       rnd_ready = 1'b0;
  logic       rnd_bit = 1'b1;
  logic       forced_ready = 1'b1;

  int         total = 0;
  int         bad = 0;
  byte        exp_q[$];
  int         m_depth = 0;
  bit         m_err = 1'b0;
  bit         stall = 1'b0;
  logic [7:0] stall_char = 8'h00;

  block_stream_gen #(.MAX_DEPTH(MAXD)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .depth     (depth),
    .balanced  (balanced),
    .err       (err)
  );

  always #5 clk = ~clk;

  assign out_ready = rnd_ready ? rnd_bit : forced_ready;

  always @(posedge clk) begin
    #1 rnd_bit = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Keyword text as plain strings; case folded when the uppercase build is used.
  function automatic byte char_of(input bit c, input int k);
    string s;
    byte   b;
    s = c ? "end " : "begin ";
    b = s[k];
`ifdef BLOCK_STREAM_GEN_UPPER_EN
    if (b >= 8'h61 && b <= 8'h7A) b = b - 8'h20;
`endif
    return b;
  endfunction

  function automatic int word_len(input bit c);
    return c ? 4 : 6;
  endfunction

  // Monitor: pops one expected byte per output handshake and checks stall holds.
  always @(negedge clk) begin
    if (reset) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_char", out_char, stall_char);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h, expected no byte at %0t", out_char, $time);
        end else begin
          check("byte", out_char, exp_q.pop_front());
        end
      end
      stall = out_valid && !out_ready;
      stall_char = out_char;
    end
  end

  task automatic send(input bit c);
    int t;
    bit legal;
    t = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd = c;
    @(negedge clk);
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    legal = c ? (m_depth > 0) : (m_depth < MAXD);
    if (legal) begin
      m_depth = c ? m_depth - 1 : m_depth + 1;
      for (int k = 0; k < word_len(c); k++) exp_q.push_back(char_of(c, k));
    end else begin
      m_err = 1'b1;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("depth", depth, m_depth);
    check("err", err, m_err);
    check("balanced", balanced, (m_depth == 0));
    if (!legal) check("illegal_no_valid", out_valid, 0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    m_depth = 0;
    m_err = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_char", out_char, 0);
    check("rst_depth", depth, 0);
    check("rst_err", err, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_balanced", balanced, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rnd_ready = 1'b0;
    forced_ready = 1'b1;
    do_reset();

    // Single BEGIN: six bytes on consecutive cycles starting the cycle after accept.
    send(1'b0);
    for (int k = 0; k < 6; k++) begin
      check("seq_valid", out_valid, 1);
      check("seq_char", out_char, char_of(1'b0, k));
      @(posedge clk);
      #1;
    end
    check("seq_done_valid", out_valid, 0);
    check("seq_depth", depth, 1);
    check("seq_balanced", balanced, 0);

    // Nested BEGIN BEGIN END END.
    do_reset();
    send(1'b0); send(1'b0); send(1'b1); send(1'b1);
    drain();
    check("nest_balanced", balanced, 1);
    check("nest_err", err, 0);

    // END at depth 0 is consumed silently, then BEGIN works and err stays set.
    do_reset();
    send(1'b1);
    send(1'b0);
    drain();
    check("err_sticky", err, 1);

    // Depth limit: BEGIN at MAXD is illegal.
    do_reset();
    for (int i = 0; i < MAXD + 1; i++) send(1'b0);
    drain();
    check("max_depth", depth, MAXD);

    // Back-pressure on 'g' for three cycles.
    do_reset();
    send(1'b0);
    begin
      int t;
      t = 0;
      while (out_char != char_of(1'b0, 2) && t < 20) begin
        @(posedge clk);
        #1;
        t++;
      end
    end
    forced_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("bp_char", out_char, char_of(1'b0, 2));
      check("bp_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    forced_ready = 1'b1;
    drain();

    // Reset after 'e' of "begin" abandons the word.
    do_reset();
    send(1'b0);
    @(posedge clk);
    #1;
    check("mid_char", out_char, char_of(1'b0, 1));
    reset = 1'b1;
    exp_q.delete();
    m_depth = 0;
    m_err = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_depth", depth, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(1'b0);
    check("restart_char", out_char, char_of(1'b0, 0));
    drain();

    // Random commands with random back-pressure.
    do_reset();
    rnd_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      send(($urandom_range(0, 99) < 55) ? 1'b0 : 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
      end
    end
    drain();
    rnd_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
